// File: rtl/l2_way_lookup_pkg.sv
// Shared L2 cache types and constants for the set lookup sequencer and its way picker.
package l2_way_lookup_pkg;

   localparam int L2_WAYS     = 8;
   localparam int L2_WAY_BITS = $clog2(L2_WAYS);
   localparam int L2_SET_BITS = 8;
   localparam int L2_TAG_BITS = 16;
   localparam int STATE_BITS  = 2;

   typedef logic [L2_SET_BITS-1:0] l2_set_t;
   typedef logic [L2_TAG_BITS-1:0] l2_tag_t;
   typedef logic [L2_WAY_BITS-1:0] l2_way_t;
   typedef logic [STATE_BITS-1:0]  state_t;

   localparam state_t INVALID = 2'b00;

   typedef enum logic [1:0] {
      LK_NONE  = 2'd0,
      LK_HIT   = 2'd1,
      LK_EMPTY = 2'd2,
      LK_EVICT = 2'd3
   } lookup_kind_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CAP,
      ST_LOOKUP,
      ST_RESP
   } lookup_state_t;

endpackage

// File: rtl/l2_way_lookup_select.sv
// Combinational way picker: hit first, then an unlocked empty way, then a round-robin
// victim starting at the buffered pointer; NONE when every candidate is locked.
module l2_way_select
   import l2_way_lookup_pkg::*;
#(
   parameter  int WAYS = L2_WAYS,
   localparam int WB   = $clog2(WAYS)
) (
   input  logic [WAYS*L2_TAG_BITS-1:0] i_tags,
   input  logic [WAYS*STATE_BITS-1:0]  i_states,
   input  logic [WAYS-1:0]             i_lock,
   input  logic [WB-1:0]               i_ptr,
   input  logic [L2_TAG_BITS-1:0]      i_tag,
   output logic [1:0]                  o_kind,
   output logic [WB-1:0]               o_way,
   output logic [WB-1:0]               o_next
);

   logic         w_hit_found;
   logic [WB-1:0] w_hit_way;
   logic         w_empty_found;
   logic [WB-1:0] w_empty_way;
   logic         w_evict_found;
   logic [WB-1:0] w_evict_way;
   logic [WB-1:0] w_idx;
   lookup_kind_t w_kind;

   // NOTE: every variable gets a default before the loops so no path leaves one unassigned (no latch).
   always_comb begin
      w_hit_found   = 1'b0;
      w_hit_way     = '0;
      w_empty_found = 1'b0;
      w_empty_way   = '0;
      w_evict_found = 1'b0;
      w_evict_way   = '0;
      w_idx         = '0;

      for (int w = 0; w < WAYS; w++) begin
         if (!w_hit_found && i_states[w*STATE_BITS +: STATE_BITS] != INVALID &&
             i_tags[w*L2_TAG_BITS +: L2_TAG_BITS] == i_tag) begin
            w_hit_found = 1'b1;
            w_hit_way   = WB'(w);
         end
         if (!w_empty_found && i_states[w*STATE_BITS +: STATE_BITS] == INVALID && !i_lock[w]) begin
            w_empty_found = 1'b1;
            w_empty_way   = WB'(w);
         end
      end

      // Index arithmetic wraps naturally at WB bits, giving the modulo-WAYS scan order.
      for (int i = 0; i < WAYS; i++) begin
         w_idx = i_ptr + WB'(i);
         if (!w_evict_found && !i_lock[w_idx]) begin
            w_evict_found = 1'b1;
            w_evict_way   = w_idx;
         end
      end
   end

   always_comb begin
      w_kind = LK_NONE;
      o_way  = '0;
      o_next = i_ptr;
      if (w_hit_found) begin
         w_kind = LK_HIT;
         o_way  = w_hit_way;
      end else if (w_empty_found) begin
         w_kind = LK_EMPTY;
         o_way  = w_empty_way;
      end else if (w_evict_found) begin
         w_kind = LK_EVICT;
         o_way  = w_evict_way;
         o_next = w_evict_way + 1'b1;
      end
   end

   assign o_kind = w_kind;

endmodule

// File: rtl/l2_way_lookup.sv
// L2 set lookup sequencer: read the set, load the set buffers, pick a way, hold the
// registered result until the controller accepts it.
module l2_way_lookup
   import l2_way_lookup_pkg::*;
#(
   parameter  int WAYS = L2_WAYS,
   localparam int WB   = $clog2(WAYS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [L2_SET_BITS-1:0]      req_set,
   input  logic [L2_TAG_BITS-1:0]      req_tag,
   input  logic [WAYS-1:0]             lock_ways,
   output logic                        rd_mem_en,
   output logic [L2_SET_BITS-1:0]      rd_set,
   output logic                        bufs_en,
   input  logic [WAYS*L2_TAG_BITS-1:0] tags_buf,
   input  logic [WAYS*STATE_BITS-1:0]  states_buf,
   input  logic [WB-1:0]               evict_way_buf,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [1:0]                  rsp_kind,
   output logic [WB-1:0]               rsp_way,
   output logic [WB-1:0]               rsp_evict_way_next
);

   lookup_state_t           r_state;
   lookup_state_t           w_next_state;
   logic [L2_SET_BITS-1:0]  r_set;
   logic [L2_TAG_BITS-1:0]  r_tag;
   logic [1:0]              r_kind;
   logic [WB-1:0]           r_way;
   logic [WB-1:0]           r_next;
   logic [1:0]              w_sel_kind;
   logic [WB-1:0]           w_sel_way;
   logic [WB-1:0]           w_sel_next;

   l2_way_select #(.WAYS(WAYS)) u_select (
      .i_tags   (tags_buf),
      .i_states (states_buf),
      .i_lock   (lock_ways),
      .i_ptr    (evict_way_buf),
      .i_tag    (r_tag),
      .o_kind   (w_sel_kind),
      .o_way    (w_sel_way),
      .o_next   (w_sel_next)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      req_ready    = 1'b0;
      rd_mem_en    = 1'b0;
      bufs_en      = 1'b0;
      rsp_valid    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next_state = ST_RD;
         end
         ST_RD: begin
            rd_mem_en    = 1'b1;
            w_next_state = ST_CAP;
         end
         ST_CAP: begin
            bufs_en      = 1'b1;
            w_next_state = ST_LOOKUP;
         end
         ST_LOOKUP: w_next_state = ST_RESP;
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_set  <= '0;
         r_tag  <= '0;
         r_kind <= LK_NONE;
         r_way  <= '0;
         r_next <= '0;
      end else begin
         if (r_state == ST_IDLE && req_valid) begin
            r_set <= req_set;
            r_tag <= req_tag;
         end
         // Result is frozen outside LOOKUP so it stays stable while the consumer stalls.
         if (r_state == ST_LOOKUP) begin
            r_kind <= w_sel_kind;
            r_way  <= w_sel_way;
            r_next <= w_sel_next;
         end
      end
   end

   assign rd_set             = r_set;
   assign rsp_kind           = r_kind;
   assign rsp_way            = r_way;
   assign rsp_evict_way_next = r_next;

endmodule

// File: tb/tb_l2_way_lookup.sv
// Self-checking bench: models the tag arrays and set buffer stage, and checks each
// lookup's timing and result against a list-based reference picker.
module tb_l2_way_lookup;
   import l2_way_lookup_pkg::*;

   localparam int W  = 8;
   localparam int TB = L2_TAG_BITS;

   logic                clk = 1'b0;
   logic                rst;
   logic                req_valid;
   logic                req_ready;
   logic [7:0]          req_set;
   logic [TB-1:0]       req_tag;
   logic [W-1:0]        lock_ways;
   logic                rd_mem_en;
   logic [7:0]          rd_set;
   logic                bufs_en;
   logic [W*TB-1:0]     tags_buf;
   logic [W*2-1:0]      states_buf;
   logic [2:0]          evict_way_buf;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [1:0]          rsp_kind;
   logic [2:0]          rsp_way;
   logic [2:0]          rsp_evict_way_next;

   logic [W*TB-1:0]     mem_tags [256];
   logic [W*2-1:0]      mem_st   [256];
   logic [2:0]          mem_ptr  [256];
   logic [W*TB-1:0]     arr_tags;
   logic [W*2-1:0]      arr_st;
   logic [2:0]          arr_ptr;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int kind;
      int way;
      int nxt;
   } exp_t;

   always #5 clk = ~clk;

   l2_way_lookup #(.WAYS(W)) dut (
      .clk                (clk),
      .rst                (rst),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_set            (req_set),
      .req_tag            (req_tag),
      .lock_ways          (lock_ways),
      .rd_mem_en          (rd_mem_en),
      .rd_set             (rd_set),
      .bufs_en            (bufs_en),
      .tags_buf           (tags_buf),
      .states_buf         (states_buf),
      .evict_way_buf      (evict_way_buf),
      .rsp_valid          (rsp_valid),
      .rsp_ready          (rsp_ready),
      .rsp_kind           (rsp_kind),
      .rsp_way            (rsp_way),
      .rsp_evict_way_next (rsp_evict_way_next)
   );

   // Array read data is valid the cycle after the strobe; the buffer stage captures it on bufs_en.
   always @(posedge clk) begin
      if (rd_mem_en) begin
         arr_tags <= mem_tags[rd_set];
         arr_st   <= mem_st[rd_set];
         arr_ptr  <= mem_ptr[rd_set];
      end
      if (bufs_en) begin
         tags_buf      <= arr_tags;
         states_buf    <= arr_st;
         evict_way_buf <= arr_ptr;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [W*TB-1:0] tags, input logic [W*2-1:0] st,
                                  input logic [W-1:0] lock, input int ptr, input logic [TB-1:0] tag);
      exp_t e;
      int   hits[$];
      int   empties[$];
      for (int w = 0; w < W; w++) begin
         if (st[w*2 +: 2] != 2'b00 && tags[w*TB +: TB] == tag) hits.push_back(w);
         if (st[w*2 +: 2] == 2'b00 && !lock[w])                empties.push_back(w);
      end
      e.kind = int'(LK_NONE); e.way = 0; e.nxt = ptr;
      if (hits.size() > 0) begin
         e.kind = int'(LK_HIT); e.way = hits[0];
      end else if (empties.size() > 0) begin
         e.kind = int'(LK_EMPTY); e.way = empties[0];
      end else begin
         for (int i = W - 1; i >= 0; i--) begin
            if (!lock[(ptr + i) % W]) begin
               e.kind = int'(LK_EVICT);
               e.way  = (ptr + i) % W;
               e.nxt  = ((ptr + i) % W + 1) % W;
            end
         end
      end
      return e;
   endfunction

   task automatic set_line(input int set, input int way, input logic [TB-1:0] tag, input logic [1:0] st);
      mem_tags[set][way*TB +: TB] = tag;
      mem_st[set][way*2 +: 2]     = st;
   endtask

   task automatic run_lookup(input logic [7:0] set, input logic [TB-1:0] tag, input logic [W-1:0] lock,
                             input int hold, input string nm);
      exp_t e;
      e = model(mem_tags[set], mem_st[set], lock, int'(mem_ptr[set]), tag);
      check({nm, "/req_ready"}, 32'(req_ready), 1);
      lock_ways = lock; req_set = set; req_tag = tag; req_valid = 1'b1; rsp_ready = (hold == 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check({nm, "/rd_mem_en"}, 32'(rd_mem_en), 1);
      check({nm, "/rd_set"}, 32'(rd_set), 32'(set));
      check({nm, "/bufs_en_rd"}, 32'(bufs_en), 0);
      @(posedge clk); #1;
      check({nm, "/bufs_en"}, 32'(bufs_en), 1);
      check({nm, "/rd_pulse"}, 32'(rd_mem_en), 0);
      @(posedge clk); #1;
      check({nm, "/bufs_pulse"}, 32'(bufs_en), 0);
      check({nm, "/early_valid"}, 32'(rsp_valid), 0);
      @(posedge clk); #1;
      check({nm, "/rsp_valid"}, 32'(rsp_valid), 1);
      check({nm, "/kind"}, 32'(rsp_kind), 32'(e.kind));
      check({nm, "/way"}, 32'(rsp_way), 32'(e.way));
      check({nm, "/next"}, 32'(rsp_evict_way_next), 32'(e.nxt));
      for (int c = 0; c < hold; c++) begin
         req_valid = 1'b1; req_set = ~set;
         @(posedge clk); #1;
         check({nm, "/hold_valid"}, 32'(rsp_valid), 1);
         check({nm, "/hold_kind"}, 32'(rsp_kind), 32'(e.kind));
         check({nm, "/hold_way"}, 32'(rsp_way), 32'(e.way));
         check({nm, "/hold_ready"}, 32'(req_ready), 0);
         check({nm, "/hold_rd"}, 32'(rd_mem_en), 0);
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      check({nm, "/done_valid"}, 32'(rsp_valid), 0);
      check({nm, "/done_ready"}, 32'(req_ready), 1);
      rsp_ready = 1'b0;
      if (e.kind == int'(LK_EVICT)) mem_ptr[set] = 3'(e.nxt);
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, "/req_ready"}, 32'(req_ready), 1);
      check({nm, "/rd_mem_en"}, 32'(rd_mem_en), 0);
      check({nm, "/rd_set"}, 32'(rd_set), 0);
      check({nm, "/bufs_en"}, 32'(bufs_en), 0);
      check({nm, "/rsp_valid"}, 32'(rsp_valid), 0);
      check({nm, "/rsp_kind"}, 32'(rsp_kind), 32'(LK_NONE));
      check({nm, "/rsp_way"}, 32'(rsp_way), 0);
      check({nm, "/rsp_next"}, 32'(rsp_evict_way_next), 0);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_set = '0; req_tag = '0; lock_ways = '0; rsp_ready = 1'b0;
      for (int s = 0; s < 256; s++) begin
         mem_tags[s] = '0; mem_st[s] = '0; mem_ptr[s] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Hit on way 5, pointer passed through.
      for (int w = 0; w < W; w++) set_line(8'h10, w, 16'h0100 + 16'(w), 2'b00);
      set_line(8'h10, 5, 16'h001A, 2'b01);
      mem_ptr[8'h10] = 3'd3;
      run_lookup(8'h10, 16'h001A, 8'h00, 0, "hit5");

      // First empty way, then the next one once way 3 is locked.
      for (int w = 0; w < W; w++) set_line(8'h11, w, 16'h0200 + 16'(w), 2'b10);
      set_line(8'h11, 3, 16'h0000, 2'b00);
      set_line(8'h11, 4, 16'h0000, 2'b00);
      run_lookup(8'h11, 16'h0055, 8'h00, 0, "empty3");
      run_lookup(8'h11, 16'h0055, 8'h08, 0, "empty4");

      // Round-robin victim wrapping past the top of the set.
      for (int w = 0; w < W; w++) set_line(8'h12, w, 16'h0300 + 16'(w), 2'b11);
      mem_ptr[8'h12] = 3'd6;
      run_lookup(8'h12, 16'h0055, 8'hC0, 0, "evict_wrap");

      // Everything locked: NONE unless a locked way hits.
      run_lookup(8'h12, 16'h0055, 8'hFF, 0, "none");
      set_line(8'h12, 2, 16'h0077, 2'b01);
      run_lookup(8'h12, 16'h0077, 8'hFF, 0, "locked_hit");

      // Consumer stall for three cycles.
      run_lookup(8'h10, 16'h001A, 8'h00, 3, "stall");

      // Reset during CAP drops the request.
      lock_ways = '0; req_set = 8'h12; req_tag = 16'h0077; req_valid = 1'b1; rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("rst_cap/bufs_en", 32'(bufs_en), 1);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_async");
      @(posedge clk); #1;
      check_reset_outputs("rst_next");
      rst = 1'b0; rsp_ready = 1'b0;
      @(posedge clk); #1;
      check("rst_after/rsp_valid", 32'(rsp_valid), 0);
      run_lookup(8'h12, 16'h0077, 8'h00, 0, "post_rst");

      // Randomised lookups over a few sets with a small tag pool so hits and conflicts recur.
      for (int n = 0; n < 40; n++) begin
         logic [7:0]    s;
         logic [W-1:0]  lk;
         s = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            for (int w = 0; w < W; w++)
               set_line(int'(s), w, 16'h0020 + 16'($urandom_range(0, 7)),
                        ($urandom_range(0, 9) < 3) ? 2'b00 : 2'($urandom_range(1, 3)));
            mem_ptr[s] = 3'($urandom_range(0, 7));
         end
         lk = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom & $urandom);
         run_lookup(s, 16'h0020 + 16'($urandom_range(0, 9)), lk, $urandom_range(0, 2), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
